// File: rtl/route_allocator.sv
// route_allocator: per-output route reservation holding input->output locks and driving crossbar selects.
// Define ROUTE_ALLOC_ROUND_ROBIN_EN for per-output round-robin arbitration; otherwise lowest input index wins.
module route_allocator #(
  parameter int N = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [N-1:0] req_valid,
  input  logic [N*REQUEST_WIDTH-1:0] req,
  input  logic [N-1:0] relieve,
  output logic [N-1:0] grant,
  output logic [N*$clog2(N)-1:0] sel,
  output logic [N-1:0] out_busy,
  output logic [N-1:0] in_routed
);
  localparam int SW = $clog2(N);
  logic [N-1:0][SW-1:0] selReg, ownOut, winIdx;
  logic [N-1:0][N-1:0] reqHit;
  logic [N-1:0] winVld;
  assign sel = selReg;
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
  logic [N-1:0][SW-1:0] rrPtr;
  always_ff @(posedge clk)
    if (!rst) rrPtr <= '0;
    else for (int o = 0; o < N; o++) if (winVld[o]) rrPtr[o] <= SW'((int'(winIdx[o]) + 1) % N);
`endif
  function automatic logic [SW-1:0] cand(input int o, input int k);
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
    return SW'((int'(rrPtr[o]) + k) % N);
`else
    return SW'(k);
`endif
  endfunction
  // An out-of-range request slice matches no output, so it is never granted.
  always_comb begin
    reqHit = '0;
    winVld = '0;
    winIdx = '0;
    for (int o = 0; o < N; o++)
      for (int i = 0; i < N; i++)
        reqHit[o][i] = req_valid[i] && !in_routed[i] && !out_busy[o] &&
                       req[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o);
    for (int o = 0; o < N; o++)
      for (int k = N - 1; k >= 0; k--)
        if (reqHit[o][cand(o, k)]) begin
          winVld[o] = 1'b1;
          winIdx[o] = cand(o, k);
        end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant <= '0;
      out_busy <= '0;
      in_routed <= '0;
      selReg <= '0;
      ownOut <= '0;
    end else begin
      grant <= '0;
      for (int i = 0; i < N; i++)
        if (relieve[i] && in_routed[i]) begin
          in_routed[i] <= 1'b0;
          out_busy[ownOut[i]] <= 1'b0;
        end
      for (int o = 0; o < N; o++)
        if (winVld[o]) begin
          out_busy[o] <= 1'b1;
          selReg[o] <= winIdx[o];
          in_routed[winIdx[o]] <= 1'b1;
          ownOut[winIdx[o]] <= SW'(o);
          grant[winIdx[o]] <= 1'b1;
        end
    end
  end
endmodule

// File: doc/route_allocator.md
# route_allocator

Switch-side route reservation stage for the mesh router. Sits directly downstream of the per-input head flit buffers: it collects each input port's route-reserve request (the destination output port), arbitrates contention per output port, and returns a one-cycle reserve-status pulse. It holds each granted input→output connection until that input's control FSM signals route relief on the tail flit, and drives the crossbar select bus.

## Interface
Parameters:
- N, 4, number of router ports (inputs = outputs); direction encoding 0 North, 1 South, 2 West, 3 East.
- REQUEST_WIDTH, 2, width of one request (output port index); must be ≥ $clog2(N).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst = 0 resets on the next clk edge).
- req_valid  in  N  per-input route-reserve request valid (held until granted).
- req  in  N*REQUEST_WIDTH  per-input requested output port, slice i at [i*REQUEST_WIDTH +: REQUEST_WIDTH].
- relieve  in  N  per-input route relieve; one-cycle pulse as the tail flit is popped.
- grant  out  N  per-input route-reserve status; one-cycle pulse.
- sel  out  N*$clog2(N)  per-output owning input index, slice o at [o*$clog2(N) +: $clog2(N)].
- out_busy  out  N  per-output locked flag; qualifies sel slice o.
- in_routed  out  N  per-input flag: input currently owns an output.

## Operation
- Per output o: two states, FREE and LOCKED(owner). Per input i: routed flag and owned output index.
- Eligible request: req_valid[i] = 1, in_routed[i] = 0, req slice < N, target output FREE. Requests with req slice ≥ N are ignored permanently (never granted).
- Each cycle, every FREE output independently picks one eligible requester; winner receives grant[i] = 1 for exactly one cycle; output → LOCKED(i), in_routed[i] → 1, sel slice o ← i.
- An input with in_routed = 1 is never granted again, even if req_valid is still high in the grant cycle.
- relieve[i] with in_routed[i] = 1: owned output → FREE, in_routed[i] → 0. relieve[i] with in_routed[i] = 0: ignored.
- sel slice of a FREE output retains its last owner value; consumers qualify with out_busy.
- Different outputs may grant in the same cycle (at most one grant per output, at most one per input by construction).

## Timing
- Reset values: grant = 0, out_busy = 0, in_routed = 0, sel = 0, all arbitration pointers = 0.
- Grant latency: eligible request sampled at edge t → grant high during cycle t+1 (registered), out_busy/in_routed high from t+1.
- Arbitration uses registered lock state only: relieve sampled at edge t frees the output at t+1; a waiting request to that output is granted at the earliest during cycle t+2.
- Simultaneous relieve and request for the same output in one cycle: request waits one cycle (no same-cycle handover).
- Reset mid-operation: all locks dropped and any pending grant suppressed; upstream must re-request.
- No combinational path from any input to any output.

## Configuration
- ROUTE_ALLOC_ROUND_ROBIN_EN defined: per-output round-robin; pointer starts search at (last winner + 1) mod N, updated only on grant.
- Undefined: fixed priority, lowest input index wins; pointers not instantiated.

## Test plan
- Single request: req_valid[2]=1, req[2]=3 at edge 1 → grant[2] pulse in cycle 2 only, out_busy[3]=1, sel slice 3 = 2, in_routed[2]=1.
- Contention: inputs 0,1,3 all request output 2 simultaneously → one grant per route; with macro order 0,1,3 across successive relieves; without macro 0,1,3 by index, input 3 starved while 0/1 re-request.
- Relief handover: input 1 owns output 0, input 2 waits on output 0; relieve[1] pulse at edge t → out_busy[0] low at t+1, grant[2] pulse in cycle t+2, sel slice 0 = 2.
- Parallel grants: inputs 0→1, 1→0, 2→3 requested together → all three grants in the same cycle, out_busy = 4'b1011.
- Spurious/invalid: relieve[3] with in_routed[3]=0 → no state change; req slice = 5 with N=4, REQUEST_WIDTH=3 → never granted.
- Reset mid-route: two routes locked, rst=0 for one edge → out_busy=0, in_routed=0, grant=0 next cycle; held requests granted anew after rst=1.
